// File: rtl/xres_reset_sequencer_if.sv
// Signal bundle between the external-reset sequencer and its environment:
// pad level, software request and seen-clear in; staged resets and status out.
interface xres_reset_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic                  xres_h_n_i;
    logic                  sw_rst_req;
    logic                  xres_seen_clr;
    logic [NUM_STAGES-1:0] stage_rst_n;
    logic                  seq_busy;
    logic                  xres_seen;
    logic                  xres_filt;
    logic [7:0]            glitch_cnt;

    modport master (
        output xres_h_n_i,
        output sw_rst_req,
        output xres_seen_clr,
        input  stage_rst_n,
        input  seq_busy,
        input  xres_seen,
        input  xres_filt,
        input  glitch_cnt
    );

    modport slave (
        input  xres_h_n_i,
        input  sw_rst_req,
        input  xres_seen_clr,
        output stage_rst_n,
        output seq_busy,
        output xres_seen,
        output xres_filt,
        output glitch_cnt
    );
endinterface

// File: rtl/xres_reset_sequencer.sv
// External reset pin synchronizer/debouncer with ordered multi-domain reset release.
// Optional rejected-glitch counter: define XRES_RESET_SEQUENCER_GLITCH_CNT_EN.
module xres_reset_sequencer #(
    parameter int NUM_STAGES      = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGE_GAP       = 8
) (
    input  logic                 clk,
    input  logic                 resetb,
    xres_reset_sequencer_if.slave bus
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W  = $clog2(HOLD_CYCLES) + 1;
    localparam int GAP_MAX = NUM_STAGES * STAGE_GAP;
    localparam int GAP_W   = $clog2(GAP_MAX) + 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_MAX - 1);

    typedef enum logic [1:0] {
        ST_ASSERT   = 2'd0,
        ST_WAIT_REL = 2'd1,
        ST_RELEASE  = 2'd2,
        ST_RUN      = 2'd3
    } state_t;

    function automatic logic [DB_W-1:0] db_inc(input logic [DB_W-1:0] v);
        return (v == DB_LAST) ? v : v + DB_W'(1);
    endfunction

    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] v);
        return (v == HOLD_LAST) ? v : v + HOLD_W'(1);
    endfunction

    function automatic logic [GAP_W-1:0] gap_inc(input logic [GAP_W-1:0] v);
        return (v == GAP_LAST) ? v : v + GAP_W'(1);
    endfunction

    logic sync_a;
    logic sync_s;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync_a <= 1'b0;
            sync_s <= 1'b0;
        end else begin
            sync_a <= bus.xres_h_n_i;
            sync_s <= sync_a;
        end
    end

    logic            filt;
    logic [DB_W-1:0] db_cnt;
    logic            differ;
    logic            filt_flip;
    logic            filt_fall;

    assign differ    = (sync_s != filt);
    assign filt_flip = differ && (db_cnt == DB_LAST);
    assign filt_fall = filt_flip && filt;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            filt   <= 1'b0;
            db_cnt <= '0;
        end else if (filt_flip) begin
            filt   <= sync_s;
            db_cnt <= '0;
        end else if (differ) begin
            db_cnt <= db_inc(db_cnt);
        end else begin
            db_cnt <= '0;
        end
    end

    state_t                state;
    state_t                state_nxt;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [HOLD_W-1:0]     hold_nxt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [GAP_W-1:0]      gap_nxt;
    logic [NUM_STAGES-1:0] stage_q;
    logic [NUM_STAGES-1:0] stage_nxt;
    logic                  first_done;
    logic                  first_nxt;
    logic                  seen;
    logic                  seen_nxt;
    logic                  pu_low;
    logic                  abort;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state      <= ST_ASSERT;
            hold_cnt   <= '0;
            gap_cnt    <= '0;
            stage_q    <= '0;
            first_done <= 1'b0;
            seen       <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            gap_cnt    <= gap_nxt;
            stage_q    <= stage_nxt;
            first_done <= first_nxt;
            seen       <= seen_nxt;
        end
    end

    // Counters are zero outside their own state, so every entry starts from a clean count.
    always_comb begin
        state_nxt = state;
        hold_nxt  = '0;
        gap_nxt   = '0;
        stage_nxt = stage_q;
        first_nxt = first_done;
        pu_low    = 1'b0;
        abort     = bus.sw_rst_req || !filt;

        case (state)
            ST_ASSERT: begin
                stage_nxt = '0;
                hold_nxt  = hold_inc(hold_cnt);
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_WAIT_REL;
                    hold_nxt  = '0;
                    first_nxt = 1'b1;
                    pu_low    = !first_done && !filt;
                end
            end
            // A low pad simply keeps us waiting here; only software restarts the hold.
            ST_WAIT_REL: begin
                stage_nxt = '0;
                if (bus.sw_rst_req) begin
                    state_nxt = ST_ASSERT;
                end else if (filt) begin
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (abort) begin
                    state_nxt = ST_ASSERT;
                    stage_nxt = '0;
                end else begin
                    gap_nxt = gap_inc(gap_cnt);
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        if (gap_cnt == GAP_W'((k + 1) * STAGE_GAP - 1)) begin
                            stage_nxt[k] = 1'b1;
                        end
                    end
                    if (gap_cnt == GAP_LAST) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                stage_nxt = '1;
                if (abort) begin
                    state_nxt = ST_ASSERT;
                    stage_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_ASSERT;
                stage_nxt = '0;
            end
        endcase

        seen_nxt = seen;
        if (bus.xres_seen_clr) begin
            seen_nxt = 1'b0;
        end
        if (filt_fall || pu_low) begin
            seen_nxt = 1'b1;
        end
    end

    assign bus.stage_rst_n = stage_q;
    assign bus.seq_busy    = (state != ST_RUN);
    assign bus.xres_seen   = seen;
    assign bus.xres_filt   = filt;

`ifdef XRES_RESET_SEQUENCER_GLITCH_CNT_EN
    logic [7:0] glitch_q;

    // A pulse is rejected when s falls back to filt before the debounce completes.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            glitch_q <= 8'h00;
        end else if (!differ && (db_cnt != '0) && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign bus.glitch_cnt = glitch_q;
`else
    assign bus.glitch_cnt = 8'h00;
`endif

    always @(posedge clk) begin
        if (resetb) begin
            assert (state != ST_RUN || stage_q == '1);
            assert (!(state == ST_ASSERT || state == ST_WAIT_REL) || stage_q == '0);
            for (int k = 1; k < NUM_STAGES; k++) begin
                assert (!stage_q[k] || stage_q[k-1]);
            end
        end
    end

endmodule

// File: tb/tb_xres_reset_sequencer.sv
// Bench for xres_reset_sequencer: directed scenarios plus random pad/sw traffic
// compared every cycle against a timing-rule model of the sequencer.
module tb_xres_reset_sequencer;

    localparam int NS   = 3;
    localparam int DB   = 4;
    localparam int HOLD = 16;
    localparam int GAP  = 8;

    localparam int M_ASSERT = 0;
    localparam int M_WAIT   = 1;
    localparam int M_REL    = 2;
    localparam int M_RUN    = 3;

`ifdef XRES_RESET_SEQUENCER_GLITCH_CNT_EN
    localparam bit GLITCH_EN = 1'b1;
`else
    localparam bit GLITCH_EN = 1'b0;
`endif

    logic clk    = 1'b0;
    logic resetb = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   ecount   = 0;
    bit   cmp_en   = 1'b0;

    xres_reset_sequencer_if #(.NUM_STAGES(NS)) bus ();

    xres_reset_sequencer #(
        .NUM_STAGES     (NS),
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES    (HOLD),
        .STAGE_GAP      (GAP)
    ) dut (
        .clk   (clk),
        .resetb(resetb),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge resetb) begin
        if (!resetb) ecount <= 0;
        else         ecount <= ecount + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ecount);
        end
    endtask

    // Model: s is the pad two samples late; filt flips after DB consecutive disagreeing
    // samples; the sequencer is a mode plus cycles elapsed since entering that mode.
    logic m_s1, m_s2, m_filt, m_seen, m_first;
    int   m_run, m_mode, m_el, m_glitch;

    always @(posedge clk or negedge resetb) begin : model
        logic nf;
        int   nm;
        bit   set_ev;
        if (!resetb) begin
            m_s1 = 0; m_s2 = 0; m_filt = 0; m_run = 0;
            m_mode = M_ASSERT; m_el = 0; m_seen = 0; m_first = 0; m_glitch = 0;
        end else begin
            nf = m_filt; nm = m_mode; set_ev = 0;
            if (m_s2 != m_filt) begin
                m_run++;
                if (m_run >= DB) begin
                    nf = m_s2;
                    m_run = 0;
                end
            end else begin
                if (m_run > 0 && GLITCH_EN && m_glitch < 255) m_glitch++;
                m_run = 0;
            end
            if (m_filt && !nf) set_ev = 1;
            case (m_mode)
                M_ASSERT: if (m_el + 1 >= HOLD) begin
                    nm = M_WAIT;
                    if (!m_first && !m_filt) set_ev = 1;
                    m_first = 1;
                end
                M_WAIT: begin
                    if (bus.sw_rst_req) nm = M_ASSERT;
                    else if (m_filt)    nm = M_REL;
                end
                M_REL: begin
                    if (bus.sw_rst_req || !m_filt) nm = M_ASSERT;
                    else if (m_el + 1 >= NS * GAP) nm = M_RUN;
                end
                default: if (bus.sw_rst_req || !m_filt) nm = M_ASSERT;
            endcase
            m_el   = (nm == m_mode) ? m_el + 1 : 0;
            m_mode = nm;
            if (set_ev)                 m_seen = 1;
            else if (bus.xres_seen_clr) m_seen = 0;
            m_filt = nf;
            m_s2   = m_s1;
            m_s1   = bus.xres_h_n_i;
        end
    end

    function automatic logic [NS-1:0] exp_stage();
        logic [NS-1:0] v = '0;
        for (int k = 0; k < NS; k++) begin
            if (m_mode == M_RUN || (m_mode == M_REL && m_el >= (k + 1) * GAP)) v[k] = 1'b1;
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("stage_rst_n", 32'(bus.stage_rst_n), 32'(exp_stage()));
            check("seq_busy",    32'(bus.seq_busy),    32'(m_mode != M_RUN));
            check("xres_seen",   32'(bus.xres_seen),   32'(m_seen));
            check("xres_filt",   32'(bus.xres_filt),   32'(m_filt));
            check("glitch_cnt",  32'(bus.glitch_cnt),  32'(m_glitch));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_run(input int budget, input string name);
        int i = 0;
        while (bus.seq_busy !== 1'b0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(bus.seq_busy), 32'd0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int t0, t1, t2, tf, bf, td, n, a, low_left;
        bus.xres_h_n_i    = 1'b1;
        bus.sw_rst_req    = 1'b0;
        bus.xres_seen_clr = 1'b0;
        tick(3);
        cmp_en = 1'b1;
        tick(1);
        check("rst_stage",  32'(bus.stage_rst_n), 32'd0);
        check("rst_busy",   32'(bus.seq_busy),    32'd1);
        check("rst_seen",   32'(bus.xres_seen),   32'd0);
        check("rst_filt",   32'(bus.xres_filt),   32'd0);
        check("rst_glitch", 32'(bus.glitch_cnt),  32'd0);

        // Power-up with the pad high.
        resetb = 1'b1;
        t0 = -1; t1 = -1; t2 = -1; tf = -1; bf = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tf < 0 && bus.xres_filt)      tf = ecount;
            if (t0 < 0 && bus.stage_rst_n[0]) t0 = ecount;
            if (t1 < 0 && bus.stage_rst_n[1]) t1 = ecount;
            if (t2 < 0 && bus.stage_rst_n[2]) t2 = ecount;
            if (bf < 0 && !bus.seq_busy)      bf = ecount;
        end
        check("pwr_filt_rise",   32'(tf), 32'd6);
        check("pwr_stage0_rise", 32'(t0), 32'd25);
        check("pwr_stage1_rise", 32'(t1), 32'd33);
        check("pwr_stage2_rise", 32'(t2), 32'd41);
        check("pwr_busy_fall",   32'(bf), 32'd41);
        check("pwr_seen",        32'(bus.xres_seen), 32'd0);

        // Three-cycle pad glitch in RUN.
        bus.xres_h_n_i = 1'b0;
        tick(3);
        bus.xres_h_n_i = 1'b1;
        tick(12);
        check("glitch_filt",  32'(bus.xres_filt),   32'd1);
        check("glitch_stage", 32'(bus.stage_rst_n), 32'd7);
        check("glitch_seen",  32'(bus.xres_seen),   32'd0);
        check("glitch_cnt1",  32'(bus.glitch_cnt),  GLITCH_EN ? 32'd1 : 32'd0);

        // Real external reset: pad low for 40 cycles.
        n = ecount; td = -1;
        bus.xres_h_n_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (td < 0 && bus.stage_rst_n == '0) td = ecount;
        end
        bus.xres_h_n_i = 1'b1;
        check("ext_drop_latency", 32'(td - n), 32'd7);
        check("ext_seen",         32'(bus.xres_seen), 32'd1);
        wait_run(150, "ext_rerelease");

        // Clear xres_seen, then software reset and mid-release abort.
        bus.xres_seen_clr = 1'b1;
        tick(1);
        bus.xres_seen_clr = 1'b0;
        tick(1);
        check("clr_seen", 32'(bus.xres_seen), 32'd0);
        n = ecount;
        bus.sw_rst_req = 1'b1;
        tick(1);
        bus.sw_rst_req = 1'b0;
        check("sw_drop",  32'(bus.stage_rst_n), 32'd0);
        check("sw_seen",  32'(bus.xres_seen),   32'd0);
        t0 = -1;
        while (ecount < n + 28) begin
            @(negedge clk);
            if (t0 < 0 && bus.stage_rst_n[0]) t0 = ecount;
        end
        check("sw_stage0_rise",  32'(t0 - n), 32'd26);
        check("abort_pre_stage", 32'(bus.stage_rst_n), 32'd1);
        bus.sw_rst_req = 1'b1;
        tick(1);
        bus.sw_rst_req = 1'b0;
        a = ecount;
        check("abort_drop", 32'(bus.stage_rst_n), 32'd0);
        t2 = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (t2 < 0 && bus.stage_rst_n[2]) t2 = ecount;
        end
        check("abort_stage2_rise", 32'(t2 - a), 32'd41);

        // Clear coincident with the filt fall: set must win.
        check("prio_seen_before", 32'(bus.xres_seen), 32'd0);
        bus.xres_h_n_i = 1'b0;
        tick(5);
        bus.xres_seen_clr = 1'b1;
        tick(1);
        bus.xres_seen_clr = 1'b0;
        check("prio_filt", 32'(bus.xres_filt), 32'd0);
        check("prio_seen", 32'(bus.xres_seen), 32'd1);
        tick(10);
        bus.xres_h_n_i = 1'b1;
        wait_run(150, "prio_rerelease");

        // Random pad pulses, software requests and clears.
        low_left = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (low_left > 0) low_left--;
            else if ($urandom_range(0, 29) == 0)
                low_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 40))
                                                        : int'($urandom_range(1, 5));
            bus.xres_h_n_i    = (low_left == 0);
            bus.sw_rst_req    = ($urandom_range(0, 99) == 0);
            bus.xres_seen_clr = ($urandom_range(0, 19) == 0);
        end
        bus.xres_h_n_i    = 1'b1;
        bus.sw_rst_req    = 1'b0;
        bus.xres_seen_clr = 1'b0;
        wait_run(200, "rand_settle");

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2;
        resetb = 1'b0;
        #1;
        check("async_stage", 32'(bus.stage_rst_n), 32'd0);
        check("async_busy",  32'(bus.seq_busy),    32'd1);
        check("async_seen",  32'(bus.xres_seen),   32'd0);
        check("async_filt",  32'(bus.xres_filt),   32'd0);

        // Power-up with the pad held low marks xres_seen on leaving ASSERT.
        bus.xres_h_n_i = 1'b0;
        tick(2);
        resetb = 1'b1;
        while (ecount < 20) @(negedge clk);
        check("pu_low_seen",  32'(bus.xres_seen), 32'd1);
        check("pu_low_stage", 32'(bus.stage_rst_n), 32'd0);
        bus.xres_h_n_i = 1'b1;
        wait_run(200, "pu_low_release");
        tick(2);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
